ps2_scancode_decoder: RTL and testbench

- Downstream stage of the PS/2 keyboard receiver. It consumes the receiver's 8-bit scan code and Ready strobe, which are in the KB_Clock domain.
- It synchronises the strobe into the system Clock domain and decodes Set-2 prefix sequences (E0 extended, F0 break, E1 pause) into single key events.
- It buffers the events in a small FIFO with a valid/ack pop interface for the consuming logic (display/LED/UART stages).

---
 rtl/ps2_scancode_decoder.sv | 276 +++++++++++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
// Takes the PS/2 receiver's scan byte and Ready strobe from the KB_Clock
// domain and brings the strobe into the Clock domain. It folds the Set-2
// prefixes (E0 extended, F0 break, E1 pause) into single key events and
// queues those events in a small FIFO with a valid/ack pop interface.
// Optional feature macro: KBD_ASCII_EN adds a Key_ascii output, and each
// FIFO entry then also stores the ASCII value from a Set-2 lookup.
module ps2_scancode_decoder #(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 50000
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [7:0]               Scan_code,
    input  logic                     Scan_ready,
    input  logic                     Event_ack,
    output logic                     Event_valid,
    output logic [7:0]               Key_code,
    output logic                     Key_extended,
    output logic                     Key_break,
    output logic [$clog2(DEPTH):0]   Fifo_count,
    output logic                     Overflow
`ifdef KBD_ASCII_EN
    ,
    output logic [7:0]               Key_ascii
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
`ifdef KBD_ASCII_EN
    localparam int ENTRY_W = 18;
`else
    localparam int ENTRY_W = 10;
`endif
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } state_t;

`ifdef KBD_ASCII_EN
    // Set-2 make code to ASCII; anything unmapped yields 0x00.
    function automatic logic [7:0] set2_to_ascii(input logic [7:0] code);
        logic [7:0] asc;
        case (code)
            8'h1C: asc = 8'h61; 8'h32: asc = 8'h62; 8'h21: asc = 8'h63;
            8'h23: asc = 8'h64; 8'h24: asc = 8'h65; 8'h2B: asc = 8'h66;
            8'h34: asc = 8'h67; 8'h33: asc = 8'h68; 8'h43: asc = 8'h69;
            8'h3B: asc = 8'h6A; 8'h42: asc = 8'h6B; 8'h4B: asc = 8'h6C;
            8'h3A: asc = 8'h6D; 8'h31: asc = 8'h6E; 8'h44: asc = 8'h6F;
            8'h4D: asc = 8'h70; 8'h15: asc = 8'h71; 8'h2D: asc = 8'h72;
            8'h1B: asc = 8'h73; 8'h2C: asc = 8'h74; 8'h3C: asc = 8'h75;
            8'h2A: asc = 8'h76; 8'h1D: asc = 8'h77; 8'h22: asc = 8'h78;
            8'h35: asc = 8'h79; 8'h1A: asc = 8'h7A;
            8'h45: asc = 8'h30; 8'h16: asc = 8'h31; 8'h1E: asc = 8'h32;
            8'h26: asc = 8'h33; 8'h25: asc = 8'h34; 8'h2E: asc = 8'h35;
            8'h36: asc = 8'h36; 8'h3D: asc = 8'h37; 8'h3E: asc = 8'h38;
            8'h46: asc = 8'h39;
            8'h29: asc = 8'h20; 8'h5A: asc = 8'h0D; 8'h66: asc = 8'h08;
            default: asc = 8'h00;
        endcase
        return asc;
    endfunction
`endif

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   ready_prev_r;
    logic                   strobe_r;
    logic [7:0]             code_r;

    state_t                 state_r, next_state_s;
    logic [2:0]             skip_r, skip_next_s;
    logic [TO_W-1:0]        tmo_r, tmo_next_s;
    logic                   tmo_hit_s;
    logic                   emit_s, emit_ext_s, emit_brk_s;

    logic [ENTRY_W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r, rd_next_s, wr_next_s;
    logic [CNT_W-1:0]       count_r, cnt_next_s, cnt_after_pop_s;
    logic                   pop_s, push_s, full_s, drop_s;
    logic [ENTRY_W-1:0]     wdata_s, head_next_s;

    // Strobe synchroniser, rising-edge detector and scan byte capture.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync_r       <= '0;
            ready_prev_r <= 1'b0;
            strobe_r     <= 1'b0;
            code_r       <= 8'h00;
        end else begin
            sync_r       <= {sync_r[SYNC_STAGES-2:0], Scan_ready};
            ready_prev_r <= sync_r[SYNC_STAGES-1];
            strobe_r     <= sync_r[SYNC_STAGES-1] & ~ready_prev_r;
            if (sync_r[SYNC_STAGES-1] & ~ready_prev_r) begin
                code_r <= Scan_code;
            end
        end
    end

    // Prefix FSM state, pause skip counter and prefix timeout counter.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_IDLE;
            skip_r  <= 3'd0;
            tmo_r   <= '0;
        end else begin
            state_r <= next_state_s;
            skip_r  <= skip_next_s;
            tmo_r   <= tmo_next_s;
        end
    end

    assign tmo_hit_s = (tmo_r == TO_LAST);

    // Prefix decode: next state, counters and the event to emit.
    always_comb begin
        next_state_s = state_r;
        skip_next_s  = skip_r;
        tmo_next_s   = '0;
        emit_s       = 1'b0;
        emit_ext_s   = 1'b0;
        emit_brk_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (strobe_r) begin
                    if (code_r == 8'hE0) begin
                        next_state_s = ST_EXT;
                    end else if (code_r == 8'hF0) begin
                        next_state_s = ST_BRK;
                    end else if (code_r == 8'hE1) begin
                        next_state_s = ST_SKIP;
                        skip_next_s  = 3'd7;
                    end else begin
                        emit_s = 1'b1;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_EXT: begin
                if (strobe_r) begin
                    if (code_r == 8'hF0) begin
                        next_state_s = ST_EXT_BRK;
                    end else if (code_r == 8'hE0) begin
                        next_state_s = ST_EXT;
                    end else begin
                        emit_s       = 1'b1;
                        emit_ext_s   = 1'b1;
                        next_state_s = ST_IDLE;
                    end
                end else if (tmo_hit_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    tmo_next_s = tmo_r + TO_W'(1);
                end
            end
            ST_BRK: begin
                if (strobe_r) begin
                    emit_s       = 1'b1;
                    emit_brk_s   = 1'b1;
                    next_state_s = ST_IDLE;
                end else if (tmo_hit_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    tmo_next_s = tmo_r + TO_W'(1);
                end
            end
            ST_EXT_BRK: begin
                if (strobe_r) begin
                    emit_s       = 1'b1;
                    emit_ext_s   = 1'b1;
                    emit_brk_s   = 1'b1;
                    next_state_s = ST_IDLE;
                end else if (tmo_hit_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    tmo_next_s = tmo_r + TO_W'(1);
                end
            end
            ST_SKIP: begin
                if (strobe_r) begin
                    if (skip_r <= 3'd1) begin
                        skip_next_s  = 3'd0;
                        next_state_s = ST_IDLE;
                    end else begin
                        skip_next_s = skip_r - 3'd1;
                    end
                end else if (tmo_hit_s) begin
                    skip_next_s  = 3'd0;
                    next_state_s = ST_IDLE;
                end else begin
                    tmo_next_s = tmo_r + TO_W'(1);
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                skip_next_s  = 3'd0;
            end
        endcase
    end

    // Entry layout, low to high: code[7:0], brk, ext, then ASCII when enabled.
`ifdef KBD_ASCII_EN
    assign wdata_s = {((emit_ext_s | emit_brk_s) ? 8'h00 : set2_to_ascii(code_r)),
                      emit_ext_s, emit_brk_s, code_r};
`else
    assign wdata_s = {emit_ext_s, emit_brk_s, code_r};
`endif

    assign full_s          = (count_r == CNT_DEPTH);
    assign pop_s           = Event_ack & Event_valid;
    assign push_s          = emit_s & (~full_s | pop_s);
    assign drop_s          = emit_s & full_s & ~pop_s;
    assign rd_next_s       = rd_ptr_r + PTR_W'(pop_s);
    assign wr_next_s       = wr_ptr_r + PTR_W'(push_s);
    assign cnt_after_pop_s = count_r - CNT_W'(pop_s);
    assign cnt_next_s      = cnt_after_pop_s + CNT_W'(push_s);

    // Head of the queue after this edge; forward a write into an empty queue.
    always_comb begin
        head_next_s = '0;
        if (push_s && (cnt_after_pop_s == '0)) begin
            head_next_s = wdata_s;
        end else if (cnt_next_s == '0) begin
            head_next_s = '0;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // FIFO storage, pointers, count, sticky overflow and registered head.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            Overflow     <= 1'b0;
            Event_valid  <= 1'b0;
            Key_code     <= 8'h00;
            Key_break    <= 1'b0;
            Key_extended <= 1'b0;
`ifdef KBD_ASCII_EN
            Key_ascii    <= 8'h00;
`endif
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wdata_s;
            end
            wr_ptr_r     <= wr_next_s;
            rd_ptr_r     <= rd_next_s;
            count_r      <= cnt_next_s;
            Overflow     <= Overflow | drop_s;
            Event_valid  <= (cnt_next_s != '0);
            Key_code     <= head_next_s[7:0];
            Key_break    <= head_next_s[8];
            Key_extended <= head_next_s[9];
`ifdef KBD_ASCII_EN
            Key_ascii    <= head_next_s[17:10];
`endif
        end
    end

    assign Fifo_count = count_r;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: a table of single bytes, each with
// its expected event, plus hand-written multi-cycle sequences for latency,
// queue ordering, timeout, overflow/wrap and reset in the middle of a sequence.
module tb_ps2_scancode_decoder;

    localparam int DEPTH   = 4;
    localparam int SYNC    = 2;
    localparam int TIMEOUT = 40;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] Scan_code = 8'h00;
    logic       Scan_ready = 1'b0;
    logic       Event_ack = 1'b0;
    logic       Event_valid;
    logic [7:0] Key_code;
    logic       Key_extended;
    logic       Key_break;
    logic [$clog2(DEPTH):0] Fifo_count;
    logic       Overflow;
`ifdef KBD_ASCII_EN
    logic [7:0] Key_ascii;
`endif

    ps2_scancode_decoder #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .Reset(Reset), .Scan_code(Scan_code), .Scan_ready(Scan_ready),
        .Event_ack(Event_ack), .Event_valid(Event_valid), .Key_code(Key_code),
        .Key_extended(Key_extended), .Key_break(Key_break), .Fifo_count(Fifo_count),
        .Overflow(Overflow)
`ifdef KBD_ASCII_EN
        , .Key_ascii(Key_ascii)
`endif
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [7:0] b;
        logic       emit;
        logic       ext;
        logic       brk;
        logic [7:0] asc;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] b, input logic e, input logic x, input logic k,
                       input logic [7:0] asc);
        vec_t v;
        v.b = b; v.emit = e; v.ext = x; v.brk = k; v.asc = asc;
        tbl.push_back(v);
    endtask

    // Scan_ready high for 4 clocks; optional one-cycle ack on the emit edge (edge 4).
    task automatic send_byte(input logic [7:0] b, input logic ack_at_emit);
        @(negedge Clock);
        Scan_code  = b;
        Scan_ready = 1'b1;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Event_ack = ack_at_emit;
        @(posedge Clock);
        @(negedge Clock);
        Event_ack  = 1'b0;
        Scan_ready = 1'b0;
        repeat (4) @(negedge Clock);
    endtask

    // Check the head entry then pop it.
    task automatic pop_check(input string name, input logic [7:0] code,
                             input logic ext, input logic brk);
        check({name, ".valid"}, {31'd0, Event_valid}, 32'd1);
        check({name, ".code"},  {24'd0, Key_code}, {24'd0, code});
        check({name, ".ext"},   {31'd0, Key_extended}, {31'd0, ext});
        check({name, ".brk"},   {31'd0, Key_break}, {31'd0, brk});
        Event_ack = 1'b1;
        @(negedge Clock);
        Event_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
    endtask

    initial begin
        add(8'h1C, 1'b1, 1'b0, 1'b0, 8'h61);
        add(8'hF0, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'h1C, 1'b1, 1'b0, 1'b1, 8'h00);
        add(8'hE0, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'h75, 1'b1, 1'b1, 1'b0, 8'h00);
        add(8'hE0, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'hF0, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'h75, 1'b1, 1'b1, 1'b1, 8'h00);
        add(8'hE0, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'hE0, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'h6B, 1'b1, 1'b1, 1'b0, 8'h00);
        add(8'hF0, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'hE0, 1'b1, 1'b0, 1'b1, 8'h00);
        add(8'hF0, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'hF0, 1'b1, 1'b0, 1'b1, 8'h00);
        add(8'hE1, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'h14, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'h77, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'hE1, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'hF0, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'h14, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'hF0, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'h77, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'h29, 1'b1, 1'b0, 1'b0, 8'h20);
        add(8'hE0, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'hF0, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'hE1, 1'b1, 1'b1, 1'b1, 8'h00);

        // Reset state.
        repeat (2) @(negedge Clock);
        check("rst.valid", {31'd0, Event_valid}, 32'd0);
        check("rst.code",  {24'd0, Key_code}, 32'd0);
        check("rst.count", {29'd0, Fifo_count}, 32'd0);
        check("rst.ovf",   {31'd0, Overflow}, 32'd0);
        Reset = 1'b1;
        @(negedge Clock);

        // Latency: Event_valid rises SYNC+2 edges after Scan_ready is first sampled.
        Scan_code  = 8'h1C;
        Scan_ready = 1'b1;
        for (int k = 1; k <= SYNC + 2; k++) begin
            @(posedge Clock);
            @(negedge Clock);
            check($sformatf("lat.edge%0d", k), {31'd0, Event_valid},
                  (k >= SYNC + 2) ? 32'd1 : 32'd0);
        end
        Scan_ready = 1'b0;
        repeat (4) @(negedge Clock);
        pop_check("lat", 8'h1C, 1'b0, 1'b0);

        // Table: one byte per vector, pop each emitted event immediately.
        for (int i = 0; i < tbl.size(); i++) begin
            send_byte(tbl[i].b, 1'b0);
            check($sformatf("vec%0d.valid", i), {31'd0, Event_valid}, {31'd0, tbl[i].emit});
            if (tbl[i].emit) begin
`ifdef KBD_ASCII_EN
                check($sformatf("vec%0d.ascii", i), {24'd0, Key_ascii}, {24'd0, tbl[i].asc});
`endif
                pop_check($sformatf("vec%0d", i), tbl[i].b, tbl[i].ext, tbl[i].brk);
            end
        end
        check("tbl.empty", {29'd0, Fifo_count}, 32'd0);

        // Queued ordering: three events held before any pop.
        send_byte(8'hF0, 1'b0); send_byte(8'h1C, 1'b0);
        send_byte(8'hE0, 1'b0); send_byte(8'h75, 1'b0);
        send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h75, 1'b0);
        check("q3.count", {29'd0, Fifo_count}, 32'd3);
        pop_check("q3.e0", 8'h1C, 1'b0, 1'b1);
        pop_check("q3.e1", 8'h75, 1'b1, 1'b0);
        pop_check("q3.e2", 8'h75, 1'b1, 1'b1);
        check("q3.empty", {29'd0, Fifo_count}, 32'd0);

        // Timeout: a stale E0 prefix is abandoned.
        send_byte(8'hE0, 1'b0);
        repeat (TIMEOUT + 5) @(negedge Clock);
        send_byte(8'h1C, 1'b0);
        check("tmo.count", {29'd0, Fifo_count}, 32'd1);
        pop_check("tmo", 8'h1C, 1'b0, 1'b0);

        // Overflow, push+pop while full, wrap, ack on empty.
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_byte(8'h16, 1'b0);
        check("full.ovf0", {31'd0, Overflow}, 32'd0);
        send_byte(8'h1E, 1'b0);
        check("ovf.count", {29'd0, Fifo_count}, DEPTH);
        check("ovf.flag",  {31'd0, Overflow}, 32'd1);
        send_byte(8'h26, 1'b1);
        check("pp.count", {29'd0, Fifo_count}, DEPTH);
        for (int i = 0; i < DEPTH - 1; i++) pop_check($sformatf("drain%0d", i), 8'h16, 1'b0, 1'b0);
        pop_check("drain.last", 8'h26, 1'b0, 1'b0);
        check("drain.count", {29'd0, Fifo_count}, 32'd0);
        Event_ack = 1'b1;
        repeat (3) @(negedge Clock);
        Event_ack = 1'b0;
        check("ackempty.count", {29'd0, Fifo_count}, 32'd0);
        check("ackempty.valid", {31'd0, Event_valid}, 32'd0);
        check("ovf.sticky", {31'd0, Overflow}, 32'd1);

        // Reset while in BRK with an event queued.
        send_byte(8'h1C, 1'b0);
        send_byte(8'hF0, 1'b0);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("midrst.valid", {31'd0, Event_valid}, 32'd0);
        check("midrst.code",  {24'd0, Key_code}, 32'd0);
        check("midrst.brk",   {31'd0, Key_break}, 32'd0);
        check("midrst.ext",   {31'd0, Key_extended}, 32'd0);
        check("midrst.count", {29'd0, Fifo_count}, 32'd0);
        check("midrst.ovf",   {31'd0, Overflow}, 32'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        send_byte(8'h1C, 1'b0);
        check("postrst.count", {29'd0, Fifo_count}, 32'd1);
`ifdef KBD_ASCII_EN
        check("postrst.ascii", {24'd0, Key_ascii}, 32'h61);
`endif
        pop_check("postrst", 8'h1C, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
